// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache-to-physical-memory arbiter.
package rv32i_types;

  localparam int ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BUSY  = 2'd1,
    D_BUSY  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Simultaneous read and write from the D-cache resolves to a write.
  function automatic logic arb_d_is_read(input logic rd, input logic wr);
    return rd & ~wr;
  endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one physical memory port.
// Optional starvation guard for the I side: define CACHE_ARBITER_STARVE_GUARD_EN.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W       = ARB_LINE_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read_i,
  input  logic [31:0]       i_addr_i,
  output logic [LINE_W-1:0] i_rdata_o,
  output logic              i_resp_o,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [31:0]       d_addr_i,
  input  logic [LINE_W-1:0] d_wdata_i,
  output logic [LINE_W-1:0] d_rdata_o,
  output logic              d_resp_o,
  output logic              pmem_read_o,
  output logic              pmem_write_o,
  output logic [31:0]       pmem_addr_o,
  output logic [LINE_W-1:0] pmem_wdata_o,
  input  logic [LINE_W-1:0] pmem_rdata_i,
  input  logic              pmem_resp_i
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("cache_arbiter: STARVE_LIMIT must be at least 1");
  end

  arb_state_t r_state;
  logic       w_d_req;
  logic       w_grant_i;
  logic       w_grant_d;

  assign w_d_req = d_read_i | d_write_i;

`ifdef CACHE_ARBITER_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;

  assign w_starved = (r_starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign w_grant_i = i_read_i & (~w_d_req | w_starved);

  // Counts back-to-back D grants taken while I is waiting; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!i_read_i) begin
      r_starve_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_grant_i) begin
        r_starve_cnt <= '0;
      end else if (w_grant_d && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end
`else
  assign w_grant_i = i_read_i & ~w_d_req;
`endif

  assign w_grant_d = w_d_req & ~w_grant_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state <= D_BUSY;
          end else if (w_grant_i) begin
            r_state <= I_BUSY;
          end
        end
        I_BUSY, D_BUSY: begin
          if (pmem_resp_i) begin
            r_state <= RELEASE;
          end
        end
        RELEASE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Owner's signals pass straight through; the response pulse is combinational.
  always_comb begin
    pmem_read_o  = 1'b0;
    pmem_write_o = 1'b0;
    pmem_addr_o  = '0;
    pmem_wdata_o = '0;
    i_resp_o     = 1'b0;
    d_resp_o     = 1'b0;
    unique case (r_state)
      I_BUSY: begin
        pmem_read_o = 1'b1;
        pmem_addr_o = i_addr_i;
        i_resp_o    = pmem_resp_i;
      end
      D_BUSY: begin
        pmem_read_o  = arb_d_is_read(d_read_i, d_write_i);
        pmem_write_o = d_write_i;
        pmem_addr_o  = d_addr_i;
        pmem_wdata_o = d_wdata_i;
        d_resp_o     = pmem_resp_i;
      end
      default: ;
    endcase
  end

  assign i_rdata_o = pmem_rdata_i;
  assign d_rdata_o = pmem_rdata_i;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed and randomized checks of cache_arbiter against a transaction-level reference model.
module tb_cache_arbiter;

  localparam int LW    = 256;
  localparam int LIMIT = 4;
`ifdef CACHE_ARBITER_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read_i;
  logic [31:0]   i_addr_i;
  logic [LW-1:0] i_rdata_o;
  logic          i_resp_o;
  logic          d_read_i;
  logic          d_write_i;
  logic [31:0]   d_addr_i;
  logic [LW-1:0] d_wdata_i;
  logic [LW-1:0] d_rdata_o;
  logic          d_resp_o;
  logic          pmem_read_o;
  logic          pmem_write_o;
  logic [31:0]   pmem_addr_o;
  logic [LW-1:0] pmem_wdata_o;
  logic [LW-1:0] pmem_rdata_i;
  logic          pmem_resp_i;

  cache_arbiter #(.LINE_W(LW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_read_i(i_read_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_resp_o(i_resp_o),
    .d_read_i(d_read_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_resp_o(d_resp_o),
    .pmem_read_o(pmem_read_o), .pmem_write_o(pmem_write_o), .pmem_addr_o(pmem_addr_o),
    .pmem_wdata_o(pmem_wdata_o), .pmem_rdata_i(pmem_rdata_i), .pmem_resp_i(pmem_resp_i)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: who holds memory (0 nobody, 1 I-cache, 2 D-cache), whether
  // this cycle is the dead cycle after a transaction, and how many D grants in a
  // row were handed out while the I-cache was asking.
  int m_owner  = 0;
  bit m_dead   = 1'b0;
  int m_streak = 0;
  int resp_seq[$];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit d_wants;
    bit i_wins;
    d_wants = d_read_i | d_write_i;
    if (rst) begin
      m_owner = 0; m_dead = 1'b0; m_streak = 0;
    end else if (m_owner != 0) begin
      if (pmem_resp_i) begin
        m_owner = 0; m_dead = 1'b1;
      end
      if (!i_read_i) m_streak = 0;
    end else if (m_dead) begin
      m_dead = 1'b0;
      if (!i_read_i) m_streak = 0;
    end else begin
      i_wins = i_read_i && (!d_wants || (GUARD && m_streak >= LIMIT));
      if (i_wins) begin
        m_owner = 1; m_streak = 0;
      end else if (d_wants) begin
        m_owner = 2;
        m_streak = i_read_i ? m_streak + 1 : 0;
      end else begin
        m_streak = 0;
      end
    end
  endtask

  // Called just after a rising edge with inputs already set for the coming cycle.
  task automatic cycle();
    logic          e_rd, e_wr, e_ir, e_dr;
    logic [31:0]   e_addr;
    logic [LW-1:0] e_wd;
    @(negedge clk);
    e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_addr = '0; e_wd = '0;
    if (m_owner == 1) begin
      e_rd = 1'b1; e_addr = i_addr_i; e_ir = pmem_resp_i;
    end else if (m_owner == 2) begin
      e_wr = d_write_i; e_rd = d_read_i & ~d_write_i;
      e_addr = d_addr_i; e_wd = d_wdata_i; e_dr = pmem_resp_i;
    end
    chk("pmem_read", LW'(pmem_read_o), LW'(e_rd));
    chk("pmem_write", LW'(pmem_write_o), LW'(e_wr));
    chk("pmem_addr", LW'(pmem_addr_o), LW'(e_addr));
    chk("pmem_wdata", pmem_wdata_o, e_wd);
    chk("i_resp", LW'(i_resp_o), LW'(e_ir));
    chk("d_resp", LW'(d_resp_o), LW'(e_dr));
    chk("i_rdata", i_rdata_o, pmem_rdata_i);
    chk("d_rdata", d_rdata_o, pmem_rdata_i);
    if (i_resp_o) resp_seq.push_back(1);
    if (d_resp_o) resp_seq.push_back(2);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    i_read_i = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0; pmem_resp_i = 1'b0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    int first_i;
    rst = 1'b1; quiet();
    i_addr_i = 32'h0; d_addr_i = 32'h0; d_wdata_i = '0; pmem_rdata_i = '0;
    @(posedge clk);
    model_edge();
    #1;
    // Reset holds everything low even with requests and memory responses present.
    i_read_i = 1'b1; d_write_i = 1'b1; pmem_resp_i = 1'b1;
    d_addr_i = 32'hDEAD_BEEF; d_wdata_i = rand_line();
    cycle();
    cycle();
    chk("reset_idle_read", LW'(pmem_read_o), '0);
    rst = 1'b0; quiet();
    cycle();

    // I-cache fill with 3-cycle memory latency.
    i_read_i = 1'b1; i_addr_i = 32'h0000_1000;
    cycle();
    i_addr_i = 32'h0000_1000;
    cycle(); cycle();
    pmem_rdata_i = rand_line(); pmem_resp_i = 1'b1;
    cycle();
    chk("i_fill_resp_seen", LW'(resp_seq.size()), LW'(1));
    i_read_i = 1'b0;
    cycle();
    pmem_resp_i = 1'b0;
    cycle();

    // Simultaneous I and D read: D first, I after the dead cycle.
    resp_seq.delete();
    i_read_i = 1'b1; i_addr_i = 32'h0000_2000;
    d_read_i = 1'b1; d_addr_i = 32'h0000_3000;
    cycle();
    cycle();
    pmem_resp_i = 1'b1; pmem_rdata_i = rand_line();
    cycle();
    d_read_i = 1'b0; pmem_resp_i = 1'b0;
    cycle(); cycle(); cycle();
    pmem_resp_i = 1'b1;
    cycle();
    quiet();
    cycle(); cycle();
    chk("dual_order_len", LW'(resp_seq.size()), LW'(2));
    if (resp_seq.size() == 2) begin
      chk("dual_first_is_d", LW'(resp_seq[0]), LW'(2));
      chk("dual_second_is_i", LW'(resp_seq[1]), LW'(1));
    end

    // Writeback, with read also raised so it must resolve to a write.
    d_write_i = 1'b1; d_read_i = 1'b1; d_addr_i = 32'h8000_0040; d_wdata_i = {32{8'hA5}};
    cycle(); cycle();
    pmem_resp_i = 1'b1;
    cycle();
    quiet();
    cycle(); cycle();

    // Reset in the middle of a D transaction, then a stray memory response.
    d_read_i = 1'b1; d_addr_i = 32'h0000_4440;
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; quiet(); pmem_resp_i = 1'b1;
    cycle(); cycle();
    pmem_resp_i = 1'b0;
    cycle();

    // Starvation: both sides hold requests, memory answers immediately.
    resp_seq.delete();
    i_read_i = 1'b1; d_read_i = 1'b1; pmem_resp_i = 1'b1;
    i_addr_i = 32'h0000_5000; d_addr_i = 32'h0000_6000;
    for (int c = 0; c < 30; c++) cycle();
    quiet();
    cycle(); cycle();
    first_i = -1;
    for (int k = resp_seq.size() - 1; k >= 0; k--) if (resp_seq[k] == 1) first_i = k;
    chk("starve_txn_count", LW'(resp_seq.size()), LW'(10));
    chk("starve_first_i_grant", LW'(first_i), GUARD ? LW'(LIMIT) : LW'(-1));

    // Randomized traffic, including dropped requests and occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst          = ($urandom_range(0, 59) == 0);
      i_read_i     = ($urandom_range(0, 2) != 0);
      d_read_i     = ($urandom_range(0, 2) == 0);
      d_write_i    = ($urandom_range(0, 3) == 0);
      i_addr_i     = $urandom;
      d_addr_i     = $urandom;
      d_wdata_i    = rand_line();
      pmem_rdata_i = rand_line();
      pmem_resp_i  = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
